// File: rtl/attocore_bus_pkg.sv
// Shared types for the attocore external memory bus arbiter.
// Pure declarations: no latency, no flow control.
package attocore_bus_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic DIR_READ  = 1'b1;
  localparam logic DIR_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_arb_select.sv
// Combinational winner pick between m0/m1; BUS_RR_EN selects round-robin, else m0 fixed priority.
// Zero latency; no backpressure (the caller only samples this in IDLE).
module bus_arb_select (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       win_vld,
  output logic       win,
  output logic       last_gnt_nxt
);

  always_comb begin
    win_vld = |req;
`ifdef BUS_RR_EN
    // last_gnt names the master granted most recently; on a tie the other one wins
    if (&req) begin
      win = ~last_gnt;
    end else begin
      win = req[1];
    end
`else
    win = ~req[0];
`endif
    last_gnt_nxt = win_vld ? win : last_gnt;
  end

endmodule

// File: rtl/attocore_bus_arbiter.sv
// Two-master byte bus arbiter (optional BUS_RR_EN round-robin); one access per WAIT_STATES+3 cycles.
// Requesters hold req until their done pulse; a losing master simply waits in IDLE arbitration.
module attocore_bus_arbiter
  import attocore_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] address_bus,
  output logic              data_dir,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic              we_q, we_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic     win_vld, win, last_nxt;
  bus_req_t m0_bus, m1_bus, sel_bus;

  assign m0_bus  = '{we: m0_we, addr: m0_addr, wdata: m0_wdata};
  assign m1_bus  = '{we: m1_we, addr: m1_addr, wdata: m1_wdata};
  assign sel_bus = win ? m1_bus : m0_bus;

  bus_arb_select u_select (
    .req          ({m1_req, m0_req}),
    .last_gnt     (last_q),
    .win_vld      (win_vld),
    .win          (win),
    .last_gnt_nxt (last_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    own_d   = own_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    done_d  = 2'b00;
    addr_d  = addr_q;
    dir_d   = dir_q;
    oe_d    = oe_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        gnt_d  = 2'b00;
        addr_d = '0;
        dir_d  = DIR_READ;
        oe_d   = 1'b0;
        dout_d = '0;
        if (win_vld) begin
          state_d = ACCESS;
          own_d   = win;
          last_d  = last_nxt;
          we_d    = sel_bus.we;
          gnt_d   = win ? 2'b10 : 2'b01;
          addr_d  = sel_bus.addr;
          dir_d   = sel_bus.we ? DIR_WRITE : DIR_READ;
          oe_d    = sel_bus.we;
          dout_d  = sel_bus.wdata;
          cnt_d   = 4'(WAIT_STATES);
        end
      end

      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (!we_q) begin
            rdata_d = data_in;
          end
          state_d = DONE;
          done_d  = own_q ? 2'b10 : 2'b01;
          dir_d   = DIR_READ;
          oe_d    = 1'b0;
        end
      end

      DONE: begin
        // gnt and address stay up through DONE; IDLE then clears them
        state_d = IDLE;
        gnt_d   = 2'b00;
        addr_d  = '0;
        dout_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      addr_q  <= '0;
      dir_q   <= DIR_READ;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0_gnt      = gnt_q[0];
  assign m1_gnt      = gnt_q[1];
  assign m0_done     = done_q[0];
  assign m1_done     = done_q[1];
  assign address_bus = addr_q;
  assign data_dir    = dir_q;
  assign data_oe     = oe_q;
  assign data_out    = dout_q;
  assign rdata       = rdata_q;

endmodule

// File: tb/tb_attocore_bus_arbiter.sv
// Bench for attocore_bus_arbiter: WAIT_STATES=1 instance for most steps, WAIT_STATES=0 for back-to-back.
// Expected completions go into a scoreboard queue and are checked when a done pulse appears.
module tb_attocore_bus_arbiter;

  logic        clock, reset;
  logic        m0_req, m0_we, m0_gnt, m0_done;
  logic [15:0] m0_addr;
  logic [7:0]  m0_wdata;
  logic        m1_req, m1_we, m1_gnt, m1_done;
  logic [15:0] m1_addr;
  logic [7:0]  m1_wdata;
  logic [7:0]  rdata, data_out, data_in;
  logic [15:0] address_bus;
  logic        data_dir, data_oe;

  logic        b_m0_req, b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done;
  logic [15:0] b_m0_addr;
  logic [7:0]  b_rdata, b_data_out, b_data_in;
  logic [15:0] b_address_bus;
  logic        b_data_dir, b_data_oe;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit m0_gnt_seen;

  typedef struct {
    logic        m;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  rd;
  } exp_t;
  exp_t sb[$];

  function automatic logic [7:0] mem(input logic [15:0] a);
    return (a == 16'h1234) ? 8'hA5 : (a[7:0] ^ a[15:8] ^ 8'h5A);
  endfunction

  assign data_in   = mem(address_bus);
  assign b_data_in = mem(b_address_bus);

  attocore_bus_arbiter #(.WAIT_STATES(1)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .rdata(rdata), .address_bus(address_bus), .data_dir(data_dir),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  attocore_bus_arbiter #(.WAIT_STATES(0)) dut_ws0 (
    .clock(clock), .reset(reset),
    .m0_req(b_m0_req), .m0_we(1'b0), .m0_addr(b_m0_addr), .m0_wdata(8'h00),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(16'h0000), .m1_wdata(8'h00),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done),
    .rdata(b_rdata), .address_bus(b_address_bus), .data_dir(b_data_dir),
    .data_out(b_data_out), .data_oe(b_data_oe), .data_in(b_data_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic we, input logic [15:0] addr);
    exp_t e;
    e.m = m; e.we = we; e.addr = addr; e.rd = mem(addr);
    sb.push_back(e);
  endtask

  // which: 0 = m0_done, 1 = m1_done, 2 = either; n = negedges waited
  task automatic wait_done(input int which, output int n);
    bit hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 60) begin
      @(negedge clock);
      n++;
      hit = (which == 0) ? m0_done : (which == 1) ? m1_done : (m0_done | m1_done);
    end
    chk("done_wait", hit, 1);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding transaction
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (m0_gnt) m0_gnt_seen = 1'b1;
      if (m0_gnt | m1_gnt) chk("gnt_onehot", m0_gnt & m1_gnt, 0);
      if (m0_done | m1_done) begin
        chk("done_onehot", m0_done & m1_done, 0);
        chk("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("done_master", m1_done, e.m);
          chk("done_gnt", e.m ? m1_gnt : m0_gnt, 1);
          chk("done_addr", address_bus, e.addr);
          if (!e.we) chk("rdata", rdata, e.rd);
        end
      end
    end
  end

  initial begin
    int n, abus, bad, acc, cnt, last_cyc;
    bit hit;
    reset = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    b_m0_req = 0; b_m0_addr = '0;

    repeat (2) @(negedge clock);
    chk("rst_addr", address_bus, 16'h0000);
    chk("rst_dir", data_dir, 1);
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_gnt_done", {m1_gnt, m0_gnt, m1_done, m0_done}, 4'b0000);
    reset = 1'b1;

    // Single m0 read: one IDLE sample cycle, WS+1 ACCESS cycles, then DONE
    @(posedge clock); #1;
    m0_we = 0; m0_addr = 16'h1234; m0_req = 1;
    push(0, 0, 16'h1234);
    n = 0; abus = 0; bad = 0; hit = 0;
    while (!hit && n < 60) begin
      @(negedge clock);
      n++;
      if (address_bus == 16'h1234) abus++;
      if (m0_gnt && (data_dir !== 1'b1 || data_oe !== 1'b0)) bad++;
      hit = m0_done;
    end
    m0_req = 0;
    chk("t1_done_seen", hit, 1);
    chk("t1_latency", n, 4);
    chk("t1_abus_cycles", abus, 3);
    chk("t1_read_dir", bad, 0);
    @(negedge clock);
    chk("t1_done_width", m0_done, 0);
    chk("t1_idle_abus", address_bus, 16'h0000);
    chk("t1_rdata_hold", rdata, 8'hA5);

    // m1 write
    m0_gnt_seen = 0;
    @(posedge clock); #1;
    m1_we = 1; m1_addr = 16'h00FF; m1_wdata = 8'h3C; m1_req = 1;
    push(1, 1, 16'h00FF);
    n = 0; bad = 0; acc = 0; hit = 0;
    while (!hit && n < 60) begin
      @(negedge clock);
      n++;
      hit = m1_done;
      if (m1_gnt && !m1_done) begin
        acc++;
        if (data_dir !== 1'b0 || data_oe !== 1'b1 || data_out !== 8'h3C) bad++;
      end
    end
    chk("t2_done_seen", hit, 1);
    chk("t2_done_oe", data_oe, 0);
    chk("t2_done_dir", data_dir, 1);
    m1_req = 0;
    chk("t2_access_cycles", acc, 2);
    chk("t2_write_drive", bad, 0);
    chk("t2_m0_gnt_never", m0_gnt_seen, 0);

    // Continuous contention for four transactions
    @(posedge clock); #1;
    m0_we = 0; m0_addr = 16'h0100;
    m1_we = 1; m1_addr = 16'h0200; m1_wdata = 8'h77;
    m0_req = 1; m1_req = 1;
`ifdef BUS_RR_EN
    push(0, 0, 16'h0100); push(1, 1, 16'h0200); push(0, 0, 16'h0100); push(1, 1, 16'h0200);
`else
    push(0, 0, 16'h0100); push(0, 0, 16'h0100); push(0, 0, 16'h0100); push(0, 0, 16'h0100);
`endif
    for (int k = 0; k < 4; k++) begin
      wait_done(2, n);
      if (k > 0) chk("t3_period", n, 4);
    end
    m0_req = 0; m1_req = 0;
    @(negedge clock);
    chk("t3_sb_drained", sb.size(), 0);

    // m0 drops req during ACCESS
    @(posedge clock); #1;
    m0_we = 0; m0_addr = 16'h0042; m0_req = 1;
    push(0, 0, 16'h0042);
    n = 0;
    while (!m0_gnt && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t4_gnt_seen", m0_gnt, 1);
    @(negedge clock);
    m0_req = 0;
    wait_done(0, n);
    cnt = 0;
    repeat (6) begin
      @(negedge clock);
      if (m0_done) cnt++;
    end
    chk("t4_single_done", cnt, 0);

    // Reset in the middle of ACCESS
    @(posedge clock); #1;
    m0_we = 0; m0_addr = 16'h0077; m0_req = 1;
    n = 0;
    while (!m0_gnt && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("t5_gnt_seen", m0_gnt, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_addr", address_bus, 16'h0000);
    chk("t5_rst_gnt", m0_gnt, 0);
    chk("t5_rst_dir", data_dir, 1);
    chk("t5_rst_rdata", rdata, 8'h00);
    m0_req = 0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clock);
      if (m0_done | m1_done | m0_gnt | m1_gnt) cnt++;
    end
    chk("t5_quiet_after", cnt, 0);
    @(posedge clock); #1;
    m1_we = 1; m1_addr = 16'h5555; m1_wdata = 8'hC3; m1_req = 1;
    push(1, 1, 16'h5555);
    wait_done(1, n);
    chk("t5_next_latency", n, 4);
    m1_req = 0;

    // WAIT_STATES=0 back-to-back reads
    @(posedge clock); #1;
    b_m0_addr = 16'h0300; b_m0_req = 1;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      hit = 0; n = 0;
      while (!hit && n < 30) begin
        @(negedge clock);
        n++;
        hit = b_m0_done;
      end
      chk("t6_done_seen", hit, 1);
      chk("t6_rdata", b_rdata, mem(16'h0300 + 16'(k)));
      if (k > 0) chk("t6_period", cyc - last_cyc, 3);
      last_cyc = cyc;
      b_m0_addr = 16'h0301 + 16'(k);
    end
    b_m0_req = 0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
